freq_ramp_nco: RTL and testbench

- Downstream consumer of the F(B) calculator.
- Accepts each new frequency tuning word (Freq[Hz]·2^32/F_clk) on its ready pulse and slews the active tuning word linearly to it over 2^ramp_log2 clocks, so the RF NCO never sees a step.
- Integrates the slewed tuning word into a 32-bit phase accumulator that drives the LLRF DDS/sine lookup.

---
 rtl/llrf_pkg.sv | 15 +
 rtl/nco_phase_acc.sv | 29 ++
 rtl/freq_ramp_nco.sv | 162 ++++++++++++++++
 tb/tb_freq_ramp_nco.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/llrf_pkg.sv
// Shared LLRF definitions: word widths, clock rate and the ramp controller state type.
package llrf_pkg;

  localparam int FREQ_W = 32;
  localparam longint F_CLK_HZ = 200_000_000;

  typedef logic [31:0] freq_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/nco_phase_acc.sv
// NCO phase accumulator: integrates a tuning word each clock, or holds phase at zero when disabled.
module nco_phase_acc #(
  parameter int W = llrf_pkg::FREQ_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] tuning_word,
  output logic [W-1:0] phase
);

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;

  always_comb begin
    phase_d = enable ? phase_q + tuning_word : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/freq_ramp_nco.sv
// Slews the NCO tuning word linearly to each newly accepted target over 2^n clocks,
// then feeds the slewed word into the phase accumulator.
module freq_ramp_nco #(
  parameter int FREQ_W   = 32,
  parameter int FRAC_W   = 16,
  parameter int MAX_LOG2 = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              freq_valid,
  input  logic [4:0]        ramp_log2,
  input  logic              enable,
  output logic [FREQ_W-1:0] tuning_word,
  output logic [FREQ_W-1:0] phase,
  output logic              ramping,
  output logic [15:0]       retarget_cnt
);
  import llrf_pkg::*;

  localparam int ACC_W  = FREQ_W + FRAC_W;
  localparam int STEP_W = FREQ_W + 1 + FRAC_W;
  localparam int CNT_W  = MAX_LOG2 + 1;

  // Input capture: rising-edge detect of freq_valid plus the operands that came with it
  logic              vld_q, vld_d;
  logic              pulse_q, pulse_d;
  logic [FREQ_W-1:0] freq_s_q, freq_s_d;
  logic [4:0]        log2_s_q, log2_s_d;

  ramp_state_t              state_q, state_d;
  logic [FREQ_W-1:0]        target_q, target_d;
  logic [4:0]               n_q, n_d;
  logic signed [STEP_W-1:0] step_q, step_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FREQ_W-1:0]        tw_q, tw_d;
  logic                     ramping_q, ramping_d;
  logic [15:0]              rc_q, rc_d;

  logic signed [FREQ_W:0]   delta;
  logic signed [STEP_W-1:0] step_shift;
  logic [ACC_W-1:0]         acc_sum;

  // One extra bit keeps full-scale moves (0 <-> all-ones) from wrapping through zero
  assign delta      = $signed({1'b0, target_q}) - $signed({1'b0, tw_q});
  assign step_shift = $signed({delta, {FRAC_W{1'b0}}}) >>> n_q;
  assign acc_sum    = ACC_W'({1'b0, acc_q} + step_q);

  always_comb begin
    vld_d    = freq_valid;
    pulse_d  = freq_valid & ~vld_q;
    freq_s_d = freq_s_q;
    log2_s_d = log2_s_q;
    if (pulse_d) begin
      freq_s_d = freq_in;
      log2_s_d = (ramp_log2 > 5'(MAX_LOG2)) ? 5'(MAX_LOG2) : ramp_log2;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    n_d      = n_q;
    step_d   = step_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tw_d     = tw_q;
    rc_d     = rc_q;

    case (state_q)
      IDLE: begin
        if (pulse_q) begin
          target_d = freq_s_q;
          n_d      = log2_s_q;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (pulse_q) begin
          target_d = freq_s_q;
          n_d      = log2_s_q;
          if (rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
        end else begin
          step_d  = step_shift;
          acc_d   = {tw_q, {FRAC_W{1'b0}}};
          cnt_d   = CNT_W'(1) << n_q;
          state_d = RAMP;
        end
      end
      RAMP: begin
        // Last step lands exactly on target so truncation residue never survives
        if (cnt_q == CNT_W'(1)) begin
          tw_d    = target_q;
          acc_d   = {target_q, {FRAC_W{1'b0}}};
          state_d = IDLE;
        end else if (!pulse_q) begin
          acc_d = acc_sum;
          tw_d  = acc_sum[FRAC_W +: FREQ_W];
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (pulse_q) begin
          target_d = freq_s_q;
          n_d      = log2_s_q;
          state_d  = LOAD;
          if (rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stays high through the edge that writes the final value
    ramping_d = (state_d != IDLE) || (state_q == RAMP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q     <= 1'b0;
      pulse_q   <= 1'b0;
      freq_s_q  <= '0;
      log2_s_q  <= '0;
      state_q   <= IDLE;
      target_q  <= '0;
      n_q       <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tw_q      <= '0;
      ramping_q <= 1'b0;
      rc_q      <= '0;
    end else begin
      vld_q     <= vld_d;
      pulse_q   <= pulse_d;
      freq_s_q  <= freq_s_d;
      log2_s_q  <= log2_s_d;
      state_q   <= state_d;
      target_q  <= target_d;
      n_q       <= n_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tw_q      <= tw_d;
      ramping_q <= ramping_d;
      rc_q      <= rc_d;
    end
  end

  nco_phase_acc #(
    .W(FREQ_W)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tuning_word(tw_q),
    .phase      (phase)
  );

  assign tuning_word  = tw_q;
  assign ramping      = ramping_q;
  assign retarget_cnt = rc_q;

endmodule

// File: tb/tb_freq_ramp_nco.sv
// Randomized scoreboard bench for freq_ramp_nco: expected per-edge outputs are queued from an
// arithmetic ramp model and a negedge monitor pops and compares them.
module tb_freq_ramp_nco;

  logic        clk;
  logic        reset;
  logic [31:0] freq_in;
  logic        freq_valid;
  logic [4:0]  ramp_log2;
  logic        enable;
  logic [31:0] tuning_word;
  logic [31:0] phase;
  logic        ramping;
  logic [15:0] retarget_cnt;

  freq_ramp_nco dut (
    .clk         (clk),
    .reset       (reset),
    .freq_in     (freq_in),
    .freq_valid  (freq_valid),
    .ramp_log2   (ramp_log2),
    .enable      (enable),
    .tuning_word (tuning_word),
    .phase       (phase),
    .ramping     (ramping),
    .retarget_cnt(retarget_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] tw;
    logic        rmp;
    logic [15:0] rc;
    logic [31:0] ph;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cur_tw = 0;
  logic [15:0] rc_m = 0;

  task automatic check(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation on the negedge after its edge
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        check("missed_slot", cyc, 64'(e.cyc), 64'(cyc));
      end else begin
        check("tuning_word", cyc, 64'(tuning_word), 64'(e.tw));
        check("ramping", cyc, 64'(ramping), 64'(e.rmp));
        check("retarget_cnt", cyc, 64'(retarget_cnt), 64'(e.rc));
        check("phase", cyc, 64'(phase), 64'(e.ph));
      end
    end
  end

  function automatic int clamp_n(input logic [4:0] l2);
    return (l2 > 5'd16) ? 16 : int'(l2);
  endfunction

  // Value after the k-th of 2^n ramp steps from s to t (fixed point with 16 fraction bits)
  function automatic logic [31:0] ramp_val(input logic [31:0] s, input logic [31:0] t, input int n, input longint k);
    longint d, step;
    if (k >= (longint'(1) << n)) return t;
    d    = (longint'(s) - longint'(s) + longint'(t) - longint'(s)) * 65536;
    step = d >>> n;
    return 32'(((longint'(s) * 65536) + k * step) >>> 16);
  endfunction

  task automatic push(input int c, input logic [31:0] tw, input logic r, input logic [31:0] ph);
    exp_t e;
    e.cyc = c; e.tw = tw; e.rmp = r; e.rc = rc_m; e.ph = ph;
    sbq.push_back(e);
  endtask

  // Pulse sampled at edge e: latch e+1, load e+2, steps e+3..e+N+2, idle from e+N+3
  task automatic build_ramp(input int e, input logic [31:0] s, input logic [31:0] t, input int n, input int lim);
    int nn;
    nn = 1 << n;
    for (int c = e + 1; c <= e + nn + 3 && c <= lim; c++) begin
      if (c <= e + 2) push(c, s, 1'b1, 32'h0);
      else if (c <= e + nn + 2) push(c, ramp_val(s, t, n, longint'(c - e - 2)), 1'b1, 32'h0);
      else push(c, t, 1'b0, 32'h0);
    end
  endtask

  task automatic pulse(input int e, input logic [31:0] t, input logic [4:0] l2, input int hold);
    while (cyc < e - 1) @(negedge clk);
    freq_in    = t;
    ramp_log2  = l2;
    freq_valid = 1'b1;
    @(negedge clk);
    repeat (hold) @(negedge clk);
    freq_valid = 1'b0;
    freq_in    = $urandom;
    ramp_log2  = 5'($urandom);
  endtask

  task automatic wait_empty(input int budget);
    int b;
    b = 0;
    while (sbq.size() != 0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (sbq.size() != 0) begin
      check("scoreboard_drain", cyc, 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  task automatic run_scn(input logic [31:0] t, input logic [4:0] l2, input int hold,
                         input bit rt, input int off, input logic [31:0] t2, input logic [4:0] l2b);
    int          e0, e1, n, n2;
    logic [31:0] s2;
    e0 = cyc + 2;
    n  = clamp_n(l2);
    n2 = clamp_n(l2b);
    e1 = e0 + off;
    if (!rt) begin
      build_ramp(e0, cur_tw, t, n, 32'h7FFF_FFFF);
      cur_tw = t;
    end else begin
      build_ramp(e0, cur_tw, t, n, e1);
      s2 = (off == (1 << n) + 1) ? t : ramp_val(cur_tw, t, n, longint'(off - 2));
      if (rc_m != 16'hFFFF) rc_m = rc_m + 16'd1;
      build_ramp(e1, s2, t2, n2, 32'h7FFF_FFFF);
      cur_tw = t2;
    end
    pulse(e0, t, l2, hold);
    if (rt) pulse(e1, t2, l2b, 0);
    wait_empty(70000);
  endtask

  initial begin
    int p, r, n, off;
    reset      = 1'b1;
    freq_in    = 32'h0;
    freq_valid = 1'b0;
    ramp_log2  = 5'd0;
    enable     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_tw", cyc, 64'(tuning_word), 64'd0);
    check("reset_phase", cyc, 64'(phase), 64'd0);
    check("reset_ramping", cyc, 64'(ramping), 64'd0);
    check("reset_rc", cyc, 64'(retarget_cnt), 64'd0);
    @(negedge clk);

    run_scn(32'h0000_1000, 5'd4, 0, 1'b0, 0, 32'h0, 5'd0);
    run_scn(32'h0000_0000, 5'd2, 0, 1'b0, 0, 32'h0, 5'd0);
    run_scn(32'h0000_0005, 5'd1, 0, 1'b0, 0, 32'h0, 5'd0);
    run_scn(32'h0000_0005, 5'd3, 0, 1'b0, 0, 32'h0, 5'd0);
    run_scn(32'h0000_0000, 5'd0, 0, 1'b0, 0, 32'h0, 5'd0);
    // Retarget mid-ramp, then retarget coinciding with the final step
    run_scn(32'h0000_1000, 5'd4, 0, 1'b1, 8, 32'h0, 5'd4);
    run_scn(32'h0000_0100, 5'd2, 0, 1'b1, 5, 32'h0000_0300, 5'd1);
    // Level held high counts once
    run_scn(32'h2345_6789, 5'd2, 30, 1'b0, 0, 32'h0, 5'd0);

    // Phase integration and wrap
    run_scn(32'h4000_0000, 5'd3, 0, 1'b0, 0, 32'h0, 5'd0);
    p = cyc + 2;
    push(p,     32'h4000_0000, 1'b0, 32'h4000_0000);
    push(p + 1, 32'h4000_0000, 1'b0, 32'h8000_0000);
    push(p + 2, 32'h4000_0000, 1'b0, 32'hC000_0000);
    push(p + 3, 32'h4000_0000, 1'b0, 32'h0000_0000);
    push(p + 4, 32'h4000_0000, 1'b0, 32'h0000_0000);
    while (cyc < p - 1) @(negedge clk);
    enable = 1'b1;
    while (cyc < p + 3) @(negedge clk);
    enable = 1'b0;
    wait_empty(100);

    // Asynchronous reset between edges in the middle of a ramp
    p = cyc + 2;
    r = p + 7;
    build_ramp(p, cur_tw, 32'h0010_0000, 4, r);
    pulse(p, 32'h0010_0000, 5'd4, 0);
    while (cyc < r) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_tw", cyc, 64'(tuning_word), 64'd0);
    check("async_rst_phase", cyc, 64'(phase), 64'd0);
    check("async_rst_ramping", cyc, 64'(ramping), 64'd0);
    check("async_rst_rc", cyc, 64'(retarget_cnt), 64'd0);
    sbq.delete();
    cur_tw = 32'h0;
    rc_m   = 16'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Full-scale up with clamped ramp length, then full-scale down
    run_scn(32'hFFFF_FFFF, 5'd31, 0, 1'b0, 0, 32'h0, 5'd0);
    run_scn(32'h0000_0000, 5'd3, 0, 1'b0, 0, 32'h0, 5'd0);

    for (int i = 0; i < 24; i++) begin
      n   = $urandom_range(0, 5);
      off = $urandom_range(2, (1 << n) + 1);
      run_scn($urandom, 5'(n), 0, 1'($urandom_range(0, 1)), off, $urandom, 5'($urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
